// File: rtl/cycle_terminator_pkg.sv
// Shared definitions for the cycle terminator and the timing state machine:
// address-mode codes, mode/timing constants, terminator states and length helpers.
package cycle_terminator_pkg;

    localparam logic [3:0] IMPLIED = 4'd0;
    localparam logic [3:0] ACCUM   = 4'd1;
    localparam logic [3:0] IMMED   = 4'd2;
    localparam logic [3:0] ZP      = 4'd3;
    localparam logic [3:0] ZPX     = 4'd4;
    localparam logic [3:0] ZPY     = 4'd5;
    localparam logic [3:0] ABS     = 4'd6;
    localparam logic [3:0] ABSX    = 4'd7;
    localparam logic [3:0] ABSY    = 4'd8;
    localparam logic [3:0] IND     = 4'd9;
    localparam logic [3:0] INDX    = 4'd10;
    localparam logic [3:0] INDY    = 4'd11;

    localparam logic ADDRESS     = 1'b0;
    localparam logic INSTRUCTION = 1'b1;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] T5 = 3'd5;
    localparam logic [2:0] T6 = 3'd6;

    typedef enum logic [1:0] {
        ST_RESET_SEQ,
        ST_ADDRESS,
        ST_EXECUTE,
        ST_PENALTY
    } term_state_t;

    // Unassigned codes (12..15) get no addressing phase, same as IMPLIED.
    function automatic logic [2:0] addr_len(input logic [3:0] code);
        case (code)
            IMMED, ZP:                    return 3'd1;
            ZPX, ZPY, ABS, ABSX, ABSY:    return 3'd2;
            IND, INDX:                    return 3'd4;
            INDY:                         return 3'd3;
            default:                      return 3'd0;
        endcase
    endfunction

    function automatic logic is_indexed(input logic [3:0] code);
        return (code == ABSX) || (code == ABSY) || (code == INDY);
    endfunction

    function automatic logic penalty_detect(input logic [3:0] code,
                                            input logic       page_cross,
                                            input logic       write_op);
        return is_indexed(code) && (page_cross || write_op);
    endfunction

    // Counter start value for an execute phase; a length of 0 runs as 1.
    function automatic logic [3:0] exec_start(input logic [2:0] len);
        return (len == 3'd0) ? 4'd0 : ({1'b0, len} - 4'd1);
    endfunction

endpackage

// File: rtl/cycle_terminator.sv
// Phase-termination strobe generator for the 6502 timing state machine.
// Optional phase/mode consistency checking is compiled in with CYCLE_CHECK_EN.
module cycle_terminator
    import cycle_terminator_pkg::*;
#(
    parameter int RESET_CYCLES = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] decodedAddress,
    input  logic [2:0] execCycles,
    input  logic       writeOp,
    input  logic       pageCross,
    input  logic       mode,
    output logic       getInstruction,
    output logic       endAddressing,
    output logic       noAddressing,
    output logic       syncError
);

    term_state_t state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [3:0]  addr_code;
    logic [2:0]  exec_len;
    logic        wr_lat;

    logic        last;
    logic        penalty;
    logic [2:0]  capture_len;

    assign last        = (cnt == 4'd0);
    assign penalty     = penalty_detect(addr_code, pageCross, wr_lat);
    assign capture_len = addr_len(decodedAddress);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RESET_SEQ;
            cnt       <= 4'(RESET_CYCLES - 1);
            addr_code <= 4'd0;
            exec_len  <= 3'd0;
            wr_lat    <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (getInstruction) begin
                addr_code <= decodedAddress;
                exec_len  <= execCycles;
                wr_lat    <= writeOp;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt - 4'd1;
        case (state)
            ST_ADDRESS: begin
                if (last) begin
                    if (penalty) begin
                        state_next = ST_PENALTY;
                    end else begin
                        state_next = ST_EXECUTE;
                        cnt_next   = exec_start(exec_len);
                    end
                end
            end
            ST_PENALTY: begin
                state_next = ST_EXECUTE;
                cnt_next   = exec_start(exec_len);
            end
            default: ;
        endcase
        // The opcode-fetch cycle overrides everything: it starts the next instruction.
        if (getInstruction) begin
            if (capture_len == 3'd0) begin
                state_next = ST_EXECUTE;
                cnt_next   = exec_start(execCycles);
            end else begin
                state_next = ST_ADDRESS;
                cnt_next   = {1'b0, capture_len} - 4'd1;
            end
        end
    end

    always_comb begin
        getInstruction = 1'b0;
        endAddressing  = 1'b0;
        case (state)
            ST_RESET_SEQ, ST_EXECUTE: getInstruction = last;
            ST_ADDRESS:               endAddressing  = last && !penalty;
            ST_PENALTY:               endAddressing  = 1'b1;
            default: ;
        endcase
        noAddressing = getInstruction && (capture_len == 3'd0);
    end

`ifdef CYCLE_CHECK_EN
    logic sync_err;
    logic phase_mismatch;

    // The start-up sequence is never checked, so the first fetch is the start point.
    always_comb begin
        phase_mismatch = 1'b0;
        case (state)
            ST_ADDRESS, ST_PENALTY: phase_mismatch = (mode != ADDRESS);
            ST_EXECUTE:             phase_mismatch = (mode != INSTRUCTION);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (phase_mismatch) begin
            sync_err <= 1'b1;
        end
    end

    assign syncError = sync_err;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign syncError   = 1'b0;
`endif

endmodule

// File: tb/tb_cycle_terminator.sv
// Directed self-checking bench for cycle_terminator (RESET_CYCLES = 7).
// The syncError test section is compiled in when CYCLE_CHECK_EN is defined.
module tb_cycle_terminator;
    import cycle_terminator_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] decodedAddress;
    logic [2:0] execCycles;
    logic       writeOp;
    logic       pageCross;
    logic       mode;
    logic       getInstruction;
    logic       endAddressing;
    logic       noAddressing;
    logic       syncError;

    int compared   = 0;
    int mismatched = 0;

    cycle_terminator #(.RESET_CYCLES(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .decodedAddress (decodedAddress),
        .execCycles     (execCycles),
        .writeOp        (writeOp),
        .pageCross      (pageCross),
        .mode           (mode),
        .getInstruction (getInstruction),
        .endAddressing  (endAddressing),
        .noAddressing   (noAddressing),
        .syncError      (syncError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] addr, input logic [2:0] exec,
                                 input logic wr, input logic pc);
        decodedAddress = addr;
        execCycles     = exec;
        writeOp        = wr;
        pageCross      = pc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic gi, input logic ea, input logic na);
        compared++;
        assert (getInstruction === gi) else begin
            mismatched++;
            $error("[TB] FAIL %s getInstruction: observed %b expected %b", tag, getInstruction, gi);
        end
        compared++;
        assert (endAddressing === ea) else begin
            mismatched++;
            $error("[TB] FAIL %s endAddressing: observed %b expected %b", tag, endAddressing, ea);
        end
        compared++;
        assert (noAddressing === na) else begin
            mismatched++;
            $error("[TB] FAIL %s noAddressing: observed %b expected %b", tag, noAddressing, na);
        end
    endtask

    task automatic checkSync(input string tag, input logic se);
        compared++;
        assert (syncError === se) else begin
            mismatched++;
            $error("[TB] FAIL %s syncError: observed %b expected %b", tag, syncError, se);
        end
    endtask

    // Releases rst and walks cycles 1..6 of the start-up count, ending in cycle 7.
    task automatic releaseAndCount(input string tag);
        rst = 1'b0;
        #1;
        checkOutput($sformatf("%s_c1", tag), 1'b0, 1'b0, 1'b0);
        for (int c = 2; c <= 6; c++) begin
            tick();
            checkOutput($sformatf("%s_c%0d", tag, c), 1'b0, 1'b0, 1'b0);
        end
        tick();
    endtask

    initial begin
        rst            = 1'b1;
        decodedAddress = IMPLIED;
        execCycles     = 3'd2;
        writeOp        = 1'b0;
        pageCross      = 1'b1;
        mode           = ADDRESS;

        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("reset_hold_%0d", i), 1'b0, 1'b0, 1'b0);
        end
        checkSync("reset_sync", 1'b0);
        pageCross = 1'b0;

        releaseAndCount("startup");
        applyStimulus(IMPLIED, 3'd2, 1'b0, 1'b0);
        checkOutput("startup_fetch", 1'b1, 1'b0, 1'b1);

        // IMPLIED, two execute cycles
        tick();
        checkOutput("impl_exec1", 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b0);
        checkOutput("impl_fetch", 1'b1, 1'b0, 1'b0);

        // ABSX without page cross; pageCross in the first cycle must be ignored
        tick();
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b1);
        checkOutput("absx_a1", 1'b0, 1'b0, 1'b0);
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b0);
        tick();
        checkOutput("absx_a2", 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b0);
        checkOutput("absx_fetch", 1'b1, 1'b0, 1'b0);

        // ABSX with page cross in the last addressing cycle
        tick();
        checkOutput("absxpc_a1", 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b1);
        checkOutput("absxpc_a2", 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(ABSX, 3'd1, 1'b0, 1'b0);
        checkOutput("absxpc_pen", 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(INDY, 3'd2, 1'b1, 1'b0);
        checkOutput("absxpc_fetch", 1'b1, 1'b0, 1'b0);

        // INDY store: penalty forced by writeOp, no page cross
        for (int c = 1; c <= 3; c++) begin
            tick();
            checkOutput($sformatf("indy_a%0d", c), 1'b0, 1'b0, 1'b0);
        end
        tick();
        checkOutput("indy_pen", 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("indy_exec1", 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(INDX, 3'd3, 1'b0, 1'b0);
        checkOutput("indy_fetch", 1'b1, 1'b0, 1'b0);

        // Reset in the second INDX addressing cycle
        tick();
        checkOutput("indx_a1", 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("indx_a2", 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("abort_now", 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("abort_held", 1'b0, 1'b0, 1'b0);
        releaseAndCount("restart");
        applyStimulus(ZP, 3'd0, 1'b1, 1'b0);
        checkOutput("restart_fetch", 1'b1, 1'b0, 1'b0);

        // ZP store: not indexed so no penalty; execCycles=0 runs one cycle
        tick();
        checkOutput("zp_a1", 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(4'd14, 3'd1, 1'b0, 1'b0);
        checkOutput("zp_fetch", 1'b1, 1'b0, 1'b1);

        // Illegal code 14 behaves as IMPLIED
        tick();
        applyStimulus(ACCUM, 3'd1, 1'b0, 1'b0);
        checkOutput("illegal_fetch", 1'b1, 1'b0, 1'b1);
`ifndef CYCLE_CHECK_EN
        checkSync("sync_tied", 1'b0);
`endif

`ifdef CYCLE_CHECK_EN
        rst = 1'b1;
        #1;
        checkSync("chk_reset", 1'b0);
        releaseAndCount("chk_start");
        applyStimulus(ABS, 3'd1, 1'b0, 1'b0);
        checkOutput("chk_fetch", 1'b1, 1'b0, 1'b0);
        tick();
        mode = INSTRUCTION;
        #1;
        checkSync("chk_a1", 1'b0);
        tick();
        mode = ADDRESS;
        #1;
        checkSync("chk_set", 1'b1);
        tick();
        mode = INSTRUCTION;
        #1;
        checkSync("chk_sticky", 1'b1);
        tick();
        checkSync("chk_sticky2", 1'b1);
        rst = 1'b1;
        #1;
        checkSync("chk_clear", 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
